draw_background_scroll: RTL and testbench

Parametrised, frame-synchronous successor of the race background renderer. It sits in the VGA pixel chain right after the timing generator and ahead of the car and sprite overlays. It draws sky, repeating pillars, kerb stripes, the two-lane road, the start line and a checkered finish line, scrolled by a world `position`. It adds a race/menu mode, configurable geometry, a two-stage pixel pipeline, and a position latch that only updates at frame boundaries, so a frame never tears.

---
 rtl/draw_bg_pkg.sv | 59 +++++
 rtl/draw_background_scroll_checker_row.sv | 54 +++++
 rtl/draw_background_scroll.sv | 173 +++++++++++++++++
 tb/tb_draw_background_scroll.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/draw_bg_pkg.sv
// Shared colours, band boundaries, scene-mode encoding and stage-1 flag bundle
// for the scrolling background renderer.
package draw_bg_pkg;

   localparam logic [11:0] SKY         = 12'h5CF;
   localparam logic [11:0] GRASS       = 12'h494;
   localparam logic [11:0] ROAD        = 12'h9AB;
   localparam logic [11:0] MIDLINE     = 12'hFF4;
   localparam logic [11:0] SIDELINE    = 12'h466;
   localparam logic [11:0] MENU_SQUARE = 12'hF52;
   localparam logic [11:0] PILLAR      = 12'h678;
   localparam logic [11:0] WHITE       = 12'hFFF;
   localparam logic [11:0] BLACK       = 12'h000;

   localparam logic [10:0] PILLAR_TOP_V_MAX  = 11'd83;
   localparam logic [10:0] PILLAR_BOT_V_MIN  = 11'd84;
   localparam logic [10:0] SKY_V_MAX         = 11'd169;
   localparam logic [10:0] KERB_V_MIN        = 11'd170;
   localparam logic [10:0] KERB_V_MAX        = 11'd223;
   localparam logic [10:0] KERB_BAND_H       = 11'd6;
   localparam logic [10:0] ROAD_SIDE_TOP_MIN = 11'd269;
   localparam logic [10:0] ROAD_SIDE_TOP_MAX = 11'd274;
   localparam logic [10:0] ROAD_UPPER_MIN    = 11'd275;
   localparam logic [10:0] ROAD_UPPER_MAX    = 11'd414;
   localparam logic [10:0] ROAD_MID_MIN      = 11'd415;
   localparam logic [10:0] ROAD_MID_MAX      = 11'd420;
   localparam logic [10:0] ROAD_LOWER_MIN    = 11'd421;
   localparam logic [10:0] ROAD_LOWER_MAX    = 11'd560;
   localparam logic [10:0] ROAD_SIDE_BOT_MIN = 11'd561;
   localparam logic [10:0] ROAD_SIDE_BOT_MAX = 11'd566;
   localparam logic [10:0] MENU_H_MIN        = 11'd312;
   localparam logic [10:0] MENU_H_MAX        = 11'd711;
   localparam logic [10:0] MENU_V_MIN        = 11'd234;
   localparam logic [10:0] MENU_V_MAX        = 11'd533;

   localparam int PILLAR_BOT_PH_MAX = 19;
   localparam int PILLAR_TOP_PH_MIN = 5;
   localparam int PILLAR_TOP_PH_MAX = 14;

   localparam logic MODE_RACE = 1'b0;
   localparam logic MODE_MENU = 1'b1;

   typedef struct packed {
      logic blank;
      logic menu;
      logic menu_sq;
      logic start;
      logic finish;
      logic fin_white;
      logic pillar;
      logic sky;
      logic kerb;
      logic kerb_side;
      logic road_side;
      logic road_mid;
      logic road_surf;
   } s1_flags_t;

endpackage

// File: rtl/draw_background_scroll_checker_row.sv
// Checker row tracker: counts lines on each hblnk rise and flips parity every
// CHECK lines, re-anchored on the line just above the start/finish band.
module bg_checker_row
   import draw_bg_pkg::*;
#(
   parameter int CHECK  = 5,
   parameter int LINE_Y = 275
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hblnk_in,
   input  logic [10:0] vcount_in,
   output logic        row_par
);

   localparam int CW = (CHECK > 1) ? $clog2(CHECK) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CHECK - 1);
   localparam logic [10:0]   ANCHOR_V = 11'(LINE_Y - 1);

   logic [CW-1:0] row_cnt_q, row_cnt_d;
   logic          row_par_q, row_par_d;
   logic          hblnk_q;

   always_comb begin
      row_cnt_d = row_cnt_q;
      row_par_d = row_par_q;
      if (hblnk_in && !hblnk_q) begin
         if (vcount_in == ANCHOR_V) begin
            row_cnt_d = '0;
            row_par_d = 1'b0;
         end else if (row_cnt_q == CNT_LAST) begin
            row_cnt_d = '0;
            row_par_d = ~row_par_q;
         end else begin
            row_cnt_d = row_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_cnt_q <= '0;
         row_par_q <= 1'b0;
         hblnk_q   <= 1'b0;
      end else begin
         row_cnt_q <= row_cnt_d;
         row_par_q <= row_par_d;
         hblnk_q   <= hblnk_in;
      end
   end

   assign row_par = row_par_q;

endmodule

// File: rtl/draw_background_scroll.sv
// Scrolling race/menu background: frame-latched position, stage-1 region
// flags, stage-2 colour mux; all outputs are the inputs delayed two clocks.
module draw_background_scroll
   import draw_bg_pkg::*;
#(
   parameter int POS_W       = 16,
   parameter int PILLAR_LOG2 = 8,
   parameter int START_X     = 580,
   parameter int FINISH_X    = 1500,
   parameter int LINE_W      = 10,
   parameter int CHECK       = 5,
   parameter int LINE_Y      = 275,
   parameter int LINE_H      = 286
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [10:0]      hcount_in,
   input  logic [10:0]      vcount_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             hblnk_in,
   input  logic             vblnk_in,
   input  logic [POS_W-1:0] position,
   input  logic             mode,
   output logic [10:0]      hcount_out,
   output logic [10:0]      vcount_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic             hblnk_out,
   output logic             vblnk_out,
   output logic [11:0]      rgb_out
);

   localparam int WW = POS_W + 1;
   localparam logic [WW-1:0] START_LO  = WW'(START_X);
   localparam logic [WW-1:0] START_HI  = WW'(START_X + LINE_W - 1);
   localparam logic [WW-1:0] FINISH_LO = WW'(FINISH_X);
   localparam logic [WW-1:0] FINISH_HI = WW'(FINISH_X + LINE_W - 1);
   localparam logic [WW-1:0] CHECK_W   = WW'(CHECK);
   localparam logic [10:0]   BAND_TOP  = 11'(LINE_Y);
   localparam logic [10:0]   BAND_BOT  = 11'(LINE_Y + LINE_H - 1);
   localparam logic [PILLAR_LOG2-1:0] PH_BOT_MAX = PILLAR_LOG2'(PILLAR_BOT_PH_MAX);
   localparam logic [PILLAR_LOG2-1:0] PH_TOP_MIN = PILLAR_LOG2'(PILLAR_TOP_PH_MIN);
   localparam logic [PILLAR_LOG2-1:0] PH_TOP_MAX = PILLAR_LOG2'(PILLAR_TOP_PH_MAX);

   logic [POS_W-1:0] pos_f_q, pos_f_d;
   logic             mode_f_q, mode_f_d;
   logic             vblnk_q;
   logic             row_par;

   logic [WW-1:0]          wx;
   logic [WW-1:0]          fin_off;
   logic [PILLAR_LOG2-1:0] ph;
   logic                   in_band;

   s1_flags_t   s1_d, s1_q;
   logic [10:0] hcount_s1_q, vcount_s1_q, hcount_s2_q, vcount_s2_q;
   logic [3:0]  sync_s1_q, sync_s2_q;
   logic [11:0] rgb_d, rgb_q;

   bg_checker_row #(
      .CHECK  (CHECK),
      .LINE_Y (LINE_Y)
   ) u_row (
      .clk       (clk),
      .reset     (reset),
      .hblnk_in  (hblnk_in),
      .vcount_in (vcount_in),
      .row_par   (row_par)
   );

   // Position/mode only move on the vblnk rise, so a frame never tears.
   always_comb begin
      pos_f_d  = pos_f_q;
      mode_f_d = mode_f_q;
      if (vblnk_in && !vblnk_q) begin
         pos_f_d  = position;
         mode_f_d = mode;
      end
   end

   assign wx      = WW'(hcount_in) + WW'(pos_f_q);
   assign fin_off = wx - FINISH_LO;
   assign ph      = wx[PILLAR_LOG2-1:0];
   assign in_band = (vcount_in >= BAND_TOP) && (vcount_in <= BAND_BOT);

   always_comb begin
      s1_d           = '0;
      s1_d.blank     = hblnk_in || vblnk_in;
      s1_d.menu      = (mode_f_q == MODE_MENU);
      s1_d.menu_sq   = (hcount_in >= MENU_H_MIN) && (hcount_in <= MENU_H_MAX) &&
                       (vcount_in >= MENU_V_MIN) && (vcount_in <= MENU_V_MAX);
      s1_d.start     = in_band && (wx >= START_LO) && (wx <= START_HI);
      s1_d.finish    = in_band && (wx >= FINISH_LO) && (wx <= FINISH_HI);
      s1_d.fin_white = (fin_off >= CHECK_W) ^ row_par;
      s1_d.pillar    = ((ph <= PH_BOT_MAX) && (vcount_in >= PILLAR_BOT_V_MIN) &&
                        (vcount_in <= SKY_V_MAX)) ||
                       ((ph >= PH_TOP_MIN) && (ph <= PH_TOP_MAX) &&
                        (vcount_in <= PILLAR_TOP_V_MAX));
      s1_d.sky       = (vcount_in <= SKY_V_MAX);
      s1_d.kerb      = (vcount_in >= KERB_V_MIN) && (vcount_in <= KERB_V_MAX);
      s1_d.kerb_side = ((((vcount_in - KERB_V_MIN) / KERB_BAND_H) & 11'd1) == 11'd0);
      s1_d.road_side = ((vcount_in >= ROAD_SIDE_TOP_MIN) && (vcount_in <= ROAD_SIDE_TOP_MAX)) ||
                       ((vcount_in >= ROAD_SIDE_BOT_MIN) && (vcount_in <= ROAD_SIDE_BOT_MAX));
      s1_d.road_mid  = (vcount_in >= ROAD_MID_MIN) && (vcount_in <= ROAD_MID_MAX);
      s1_d.road_surf = ((vcount_in >= ROAD_UPPER_MIN) && (vcount_in <= ROAD_UPPER_MAX)) ||
                       ((vcount_in >= ROAD_LOWER_MIN) && (vcount_in <= ROAD_LOWER_MAX));
   end

   always_comb begin
      rgb_d = GRASS;
      if (s1_q.blank) begin
         rgb_d = BLACK;
      end else if (s1_q.menu) begin
         if (s1_q.menu_sq)  rgb_d = MENU_SQUARE;
         else if (s1_q.sky) rgb_d = SKY;
         else               rgb_d = GRASS;
      end else if (s1_q.start) begin
         rgb_d = WHITE;
      end else if (s1_q.finish) begin
         rgb_d = s1_q.fin_white ? WHITE : BLACK;
      end else if (s1_q.pillar) begin
         rgb_d = PILLAR;
      end else if (s1_q.sky) begin
         rgb_d = SKY;
      end else if (s1_q.kerb) begin
         rgb_d = s1_q.kerb_side ? SIDELINE : ROAD;
      end else if (s1_q.road_side) begin
         rgb_d = SIDELINE;
      end else if (s1_q.road_mid) begin
         rgb_d = MIDLINE;
      end else if (s1_q.road_surf) begin
         rgb_d = ROAD;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos_f_q     <= '0;
         mode_f_q    <= MODE_RACE;
         vblnk_q     <= 1'b0;
         s1_q        <= '0;
         hcount_s1_q <= '0;
         vcount_s1_q <= '0;
         sync_s1_q   <= '0;
         hcount_s2_q <= '0;
         vcount_s2_q <= '0;
         sync_s2_q   <= '0;
         rgb_q       <= '0;
      end else begin
         pos_f_q     <= pos_f_d;
         mode_f_q    <= mode_f_d;
         vblnk_q     <= vblnk_in;
         s1_q        <= s1_d;
         hcount_s1_q <= hcount_in;
         vcount_s1_q <= vcount_in;
         sync_s1_q   <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
         hcount_s2_q <= hcount_s1_q;
         vcount_s2_q <= vcount_s1_q;
         sync_s2_q   <= sync_s1_q;
         rgb_q       <= rgb_d;
      end
   end

   assign hcount_out = hcount_s2_q;
   assign vcount_out = vcount_s2_q;
   assign hsync_out  = sync_s2_q[3];
   assign vsync_out  = sync_s2_q[2];
   assign hblnk_out  = sync_s2_q[1];
   assign vblnk_out  = sync_s2_q[0];
   assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_draw_background_scroll.sv
// Scoreboard bench: driver pushes model-predicted pixels, monitor pops and
// compares them two clocks later.
module tb_draw_background_scroll;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [10:0] hcount_in = '0, vcount_in = '0;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [15:0] position = '0;
   logic        mode = 1'b0;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   draw_background_scroll dut (
      .clk(clk), .reset(reset),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .position(position), .mode(mode),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          stamp;
      logic [10:0] h, v;
      logic        hs, vs, hb, vb;
      logic [11:0] rgb;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_err = 0;
   bit   push_en = 0;

   // reference state: latched scene and hblnk rises since last anchor/reset
   int m_pos, m_edges;
   bit m_mode, m_prev_vb, m_prev_hb;

   function automatic void model_reset();
      m_pos = 0; m_mode = 0; m_edges = 0; m_prev_vb = 0; m_prev_hb = 0;
   endfunction

   function automatic bit m_par();
      return bit'((m_edges / 5) % 2);
   endfunction

   function automatic logic [11:0] ref_rgb(int h, int v, bit hb, bit vb, int pos, bit md, bit par);
      int wx, ph;
      bit band;
      if (hb || vb) return 12'h000;
      if (md) begin
         if (h >= 312 && h <= 711 && v >= 234 && v <= 533) return 12'hF52;
         if (v <= 169) return 12'h5CF;
         return 12'h494;
      end
      wx = (h + pos) % 131072;
      ph = wx % 256;
      band = (v >= 275) && (v <= 560);
      if (band && wx >= 580 && wx <= 589) return 12'hFFF;
      if (band && wx >= 1500 && wx <= 1509)
         return ((((wx - 1500) >= 5) ? 1'b1 : 1'b0) ^ par) ? 12'hFFF : 12'h000;
      if ((ph <= 19 && v >= 84 && v <= 169) || (ph >= 5 && ph <= 14 && v <= 83)) return 12'h678;
      if (v <= 169) return 12'h5CF;
      if (v <= 223) return (((v - 170) / 6) % 2 == 0) ? 12'h466 : 12'h9AB;
      if (v >= 269 && v <= 274) return 12'h466;
      if (v >= 275 && v <= 414) return 12'h9AB;
      if (v >= 415 && v <= 420) return 12'hFF4;
      if (v >= 421 && v <= 560) return 12'h9AB;
      if (v >= 561 && v <= 566) return 12'h466;
      return 12'h494;
   endfunction

   task automatic drive(input int h, input int v, input bit hb, input bit vb, input bit hs, input bit vs);
      exp_t e;
      @(posedge clk); #2;
      hcount_in = 11'(h); vcount_in = 11'(v);
      hblnk_in = hb; vblnk_in = vb; hsync_in = hs; vsync_in = vs;
      e.stamp = cyc; e.h = 11'(h); e.v = 11'(v);
      e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
      e.rgb = ref_rgb(h, v, hb, vb, m_pos, m_mode, m_par());
      if (push_en) q.push_back(e);
      if (vb && !m_prev_vb) begin m_pos = int'(position); m_mode = mode; end
      if (hb && !m_prev_hb) begin
         if (v == 274) m_edges = 0;
         else m_edges++;
      end
      m_prev_vb = vb; m_prev_hb = hb;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0 && q[0].stamp + 2 <= cyc) begin
         e = q.pop_front();
         n_checks += 2;
         if (e.stamp + 2 != cyc) begin
            n_err += 2;
            $display("FAIL sched: entry stamp %0d popped at cycle %0d", e.stamp, cyc);
         end else begin
            if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !==
                {e.h, e.v, e.hs, e.vs, e.hb, e.vb}) begin
               n_err++;
               $display("FAIL timing: got h=%0d v=%0d hs%b vs%b hb%b vb%b want h=%0d v=%0d hs%b vs%b hb%b vb%b",
                        hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                        e.h, e.v, e.hs, e.vs, e.hb, e.vb);
            end
            if (rgb_out !== e.rgb) begin
               n_err++;
               $display("FAIL rgb (h=%0d v=%0d): got %h want %h", e.h, e.v, rgb_out, e.rgb);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_checks++; n_err++;
         $display("FAIL drain: %0d entries never presented, want 0", q.size());
         q.delete();
      end
   endtask

   task automatic mid_reset();
      logic [11:0] want;
      drain();
      push_en = 0;
      want = ref_rgb(300, 50, 0, 0, m_pos, m_mode, m_par());
      repeat (3) drive(300, 50, 0, 0, 1, 1);
      #1;
      check("pre_reset_rgb", 32'(rgb_out), 32'(want));
      reset = 1'b0;
      #1;
      check("mid_reset_rgb", 32'(rgb_out), 32'h0);
      check("mid_reset_timing", {16'h0, hcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
            32'h0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      model_reset();
      push_en = 1;
   endtask

   function automatic bit sweep_line(int v);
      return v == 100 || v == 275 || v == 280 || v == 300 || v == 559 || v == 560;
   endfunction

   task automatic run_frame(input int sw_lo, input int sw_hi, input int mid_pos, input int next_pos,
                            input bit next_mode, input bit rand_blank, input int reset_line);
      bit vb;
      for (int v = 0; v < 628; v++) begin
         if (v == 200) position = 16'(mid_pos);
         if (v == 600) begin position = 16'(next_pos); mode = next_mode; end
         if (v == reset_line) mid_reset();
         vb = (v >= 600);
         for (int k = 0; k < 4; k++)
            drive(int'($urandom_range(0, 799)), v,
                  rand_blank && ($urandom_range(0, 7) == 0), vb,
                  1'($urandom), 1'($urandom));
         if (sweep_line(v))
            for (int h = sw_lo; h <= sw_hi; h++) drive(h, v, 0, vb, 1'($urandom), 1'($urandom));
         drive(800, v, 1, vb, 1, 1'($urandom));
         drive(801, v, 1, vb, 0, 1'($urandom));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached with %0d entries pending", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) drive(10, 100, 0, 0, 1, 1);
      @(negedge clk);
      check("reset_rgb", 32'(rgb_out), 32'h0);
      check("reset_hcount", 32'(hcount_out), 32'h0);
      check("reset_sync", {28'h0, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'h0);
      #2 reset = 1'b1;
      model_reset();
      push_en = 1;
      drive(10, 100, 0, 0, 0, 0);
      drive(10, 100, 0, 0, 1, 0);
      drive(200, 300, 0, 0, 0, 1);

      run_frame(575, 594, 100, 100, 0, 0, -1);    // start line at 580, latch 100
      run_frame(475, 494, 777, 1000, 0, 0, -1);   // start line at 480, latch 1000
      run_frame(495, 514, 5, 250, 0, 0, -1);      // finish checker at 500..509
      run_frame(0, 275, 3, int'($urandom_range(0, 65535)), 1, 0, -1);  // pillar wrap
      run_frame(300, 320, 44, 1400, 1, 1, -1);    // menu scene
      drive(400, 300, 0, 0, 0, 0);
      drive(100, 100, 0, 0, 0, 0);
      drive(100, 600, 0, 0, 0, 0);
      drive(711, 533, 0, 0, 0, 0);
      drive(712, 533, 0, 0, 0, 0);
      drive(50, 300, 1, 0, 1, 0);
      drive(50, 300, 0, 0, 0, 1);
      run_frame(570, 600, int'($urandom_range(0, 65535)), 65500, 0, 1, 350);
      run_frame(0, 40, 9, int'($urandom_range(0, 2000)), 0, 1, -1);
      run_frame(480, 520, 1, 0, 0, 1, -1);
      drain();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
